// File: rtl/rgb_pkg.sv
// Shared types for the RGB hue cycler: run modes, hue segments and the
// per-channel role each segment assigns to R, G and B.
package rgb_pkg;

  typedef enum logic [1:0] {CYCLE = 2'd0, HOLD = 2'd1, STEP = 2'd2, OFF = 2'd3} mode_t;

  typedef enum logic [2:0] {
    GREEN_INC = 3'd0,
    RED_DEC   = 3'd1,
    BLUE_INC  = 3'd2,
    GREEN_DEC = 3'd3,
    RED_INC   = 3'd4,
    BLUE_DEC  = 3'd5
  } seg_t;

  typedef enum logic [1:0] {FULL = 2'd0, OFF_R = 2'd1, UP = 2'd2, DOWN = 2'd3} role_t;

  // Channel index: 0 = red, 1 = green, 2 = blue.
  function automatic role_t seg_role(input seg_t seg, input logic [1:0] ch);
    role_t r;
    role_t g;
    role_t b;
    case (seg)
      GREEN_INC: begin r = FULL;  g = UP;    b = OFF_R; end
      RED_DEC:   begin r = DOWN;  g = FULL;  b = OFF_R; end
      BLUE_INC:  begin r = OFF_R; g = FULL;  b = UP;    end
      GREEN_DEC: begin r = OFF_R; g = DOWN;  b = FULL;  end
      RED_INC:   begin r = UP;    g = OFF_R; b = FULL;  end
      BLUE_DEC:  begin r = FULL;  g = OFF_R; b = DOWN;  end
      default:   begin r = OFF_R; g = OFF_R; b = OFF_R; end
    endcase
    case (ch)
      2'd0:    return r;
      2'd1:    return g;
      default: return b;
    endcase
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM output: pending/active duty pair so a period is never torn, and a
// registered active-low pin.
module rgb_pwm_channel #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          load,
  input  logic [DW-1:0] pwm_cnt,
  input  logic [DW-1:0] duty,
  output logic          pin
);

  logic [DW-1:0] pending;
  logic [DW-1:0] active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      active  <= '0;
      pin     <= 1'b1;
    end else begin
      pending <= duty;
      if (load) active <= pending;
      pin <= run ? ~(pwm_cnt < active) : 1'b1;
    end
  end

endmodule

// File: rtl/rgb_hue_cycler.sv
// Hue-wheel walker: six ramp segments, brightness scaling and three
// active-low PWM LED outputs with run-mode and direction control.
module rgb_hue_cycler
  import rgb_pkg::*;
#(
  parameter int PWM_INTERVAL = 1000,
  parameter int STEP_CYCLES  = 2000,
  parameter int BRIGHT_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic                   dir,
  input  logic                   step_pulse,
  input  logic [BRIGHT_BITS-1:0] brightness,
  output logic                   RGB_R,
  output logic                   RGB_G,
  output logic                   RGB_B,
  output logic [2:0]             segment,
  output logic                   wrap
);

  localparam int DW = $clog2(PWM_INTERVAL + 1);
  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam int PW = DW + BRIGHT_BITS + 1;
  localparam logic [DW-1:0] LAST      = DW'(PWM_INTERVAL - 1);
  localparam logic [DW-1:0] FULL_DUTY = DW'(PWM_INTERVAL);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  mode_t         mode_i;
  seg_t          seg;
  logic [DW-1:0] ramp;
  logic [DW-1:0] pwm_cnt;
  logic [SW-1:0] step_cnt;
  logic          run;
  logic          tick;
  logic          load;
  logic [2:0]    pins;
  logic [DW-1:0] duty [3];

  assign mode_i = mode_t'(mode);
  assign run    = en && (mode_i != OFF);
  assign tick   = en && (((mode_i == CYCLE) && (step_cnt == STEP_LAST)) ||
                         ((mode_i == STEP) && step_pulse));
  // Idle PWM keeps active duty tracking pending, so re-enable starts current.
  assign load   = !run || (pwm_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg      <= GREEN_INC;
      ramp     <= '0;
      step_cnt <= '0;
      pwm_cnt  <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (mode_i == STEP) step_cnt <= '0;
      else if (en && (mode_i == CYCLE))
        step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + SW'(1);

      if (tick) begin
        if (!dir) begin
          if (ramp == LAST) begin
            ramp <= '0;
            seg  <= (seg == BLUE_DEC) ? GREEN_INC : seg_t'(seg + 3'd1);
            wrap <= (seg == BLUE_DEC);
          end else begin
            ramp <= ramp + DW'(1);
          end
        end else begin
          if (ramp == '0) begin
            ramp <= LAST;
            seg  <= (seg == GREEN_INC) ? BLUE_DEC : seg_t'(seg - 3'd1);
            wrap <= (seg == GREEN_INC);
          end else begin
            ramp <= ramp - DW'(1);
          end
        end
      end

      if (!run || (pwm_cnt == LAST)) pwm_cnt <= '0;
      else                           pwm_cnt <= pwm_cnt + DW'(1);
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [DW-1:0]          raw;
    logic [BRIGHT_BITS:0]   scale;
    logic [PW-1:0]          prod;

    always_comb begin
      raw = '0;
      case (seg_role(seg, 2'(ch)))
        FULL:    raw = FULL_DUTY;
        OFF_R:   raw = '0;
        UP:      raw = ramp;
        DOWN:    raw = LAST - ramp;
        default: raw = '0;
      endcase
      scale    = {1'b0, brightness} + (BRIGHT_BITS + 1)'(1);
      prod     = PW'(raw) * PW'(scale);
      duty[ch] = DW'(prod >> BRIGHT_BITS);
    end

    rgb_pwm_channel #(.DW(DW)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .load    (load),
      .pwm_cnt (pwm_cnt),
      .duty    (duty[ch]),
      .pin     (pins[ch])
    );
  end

  assign RGB_R   = pins[0];
  assign RGB_G   = pins[1];
  assign RGB_B   = pins[2];
  assign segment = seg;

endmodule

// File: tb/tb_rgb_hue_cycler.sv
// Directed bench for rgb_hue_cycler with PWM_INTERVAL=8, STEP_CYCLES=4,
// BRIGHT_BITS=8; inputs change and outputs are sampled on negedges.
module tb_rgb_hue_cycler;

  localparam int PWM = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       dir;
  logic       step_pulse;
  logic [7:0] brightness;
  logic       RGB_R, RGB_G, RGB_B;
  logic [2:0] segment;
  logic       wrap;

  int total = 0;
  int bad   = 0;
  int wrap_cnt;
  int r_low, g_low, b_low;

  rgb_hue_cycler #(.PWM_INTERVAL(8), .STEP_CYCLES(4), .BRIGHT_BITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .dir        (dir),
    .step_pulse (step_pulse),
    .brightness (brightness),
    .RGB_R      (RGB_R),
    .RGB_G      (RGB_G),
    .RGB_B      (RGB_B),
    .segment    (segment),
    .wrap       (wrap)
  );

  // clock / watchdog
  initial forever #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_count(input int n);
    repeat (n) begin
      @(negedge clk);
      if (wrap) wrap_cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
  endtask

  task automatic pulse();
    step_pulse = 1'b1;
    cycles(1);
    step_pulse = 1'b0;
    cycles(1);
  endtask

  // Low (LED on) cycles of each pin over one PWM period.
  task automatic measure(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    repeat (PWM) begin
      cycles(1);
      if (!RGB_R) r++;
      if (!RGB_G) g++;
      if (!RGB_B) b++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_r"}, RGB_R, 1);
    check_eq({tag, "_g"}, RGB_G, 1);
    check_eq({tag, "_b"}, RGB_B, 1);
    check_eq({tag, "_seg"}, segment, 0);
    check_eq({tag, "_wrap"}, wrap, 0);
  endtask

  initial begin
    bit prev_g;
    bit found;
    rst_n = 1'b0; en = 1'b1; mode = 2'd0; dir = 1'b0;
    step_pulse = 1'b0; brightness = 8'd255;

    // reset at power-up and mid-run
    cycles(3);
    check_reset_state("rst_init");
    rst_n = 1'b1;
    cycles(50);
    check_eq("pre_rst_seg", segment, 1);
    do_reset();
    check_reset_state("rst_mid");

    // free-running cycle through all six segments
    wrap_cnt = 0;
    run_count(31);
    check_eq("cyc_seg_31", segment, 0);
    run_count(1);
    check_eq("cyc_seg_32", segment, 1);
    for (int s = 2; s <= 5; s++) begin
      run_count(32);
      check_eq($sformatf("cyc_seg_%0d", s), segment, s);
    end
    run_count(31);
    check_eq("cyc_no_early_wrap", wrap_cnt, 0);
    cycles(1);
    check_eq("cyc_wrap_hi", wrap, 1);
    check_eq("cyc_seg_back0", segment, 0);
    cycles(1);
    check_eq("cyc_wrap_lo", wrap, 0);

    // seg 0 ramp 4 duty at full and half brightness
    mode = 2'd2;
    do_reset();
    repeat (4) pulse();
    cycles(20);
    measure(r_low, g_low, b_low);
    check_eq("b255_r", r_low, 8);
    check_eq("b255_g", g_low, 4);
    check_eq("b255_b", b_low, 0);
    brightness = 8'd127;
    cycles(20);
    measure(r_low, g_low, b_low);
    check_eq("b127_r", r_low, 4);
    check_eq("b127_g", g_low, 2);
    brightness = 8'd255;

    // STEP mode: no free advance, pulses counted, pulses ignored in HOLD
    do_reset();
    cycles(50);
    measure(r_low, g_low, b_low);
    check_eq("step_idle_g", g_low, 0);
    check_eq("step_idle_seg", segment, 0);
    repeat (3) pulse();
    cycles(20);
    measure(r_low, g_low, b_low);
    check_eq("step3_g", g_low, 3);
    check_eq("step3_r", r_low, 8);
    mode = 2'd1;
    repeat (2) pulse();
    mode = 2'd2;
    cycles(20);
    measure(r_low, g_low, b_low);
    check_eq("hold_pulse_ign_g", g_low, 3);

    // reverse across the wrap point
    do_reset();
    dir = 1'b1;
    step_pulse = 1'b1;
    cycles(1);
    step_pulse = 1'b0;
    check_eq("rev_seg", segment, 5);
    check_eq("rev_wrap_hi", wrap, 1);
    cycles(1);
    check_eq("rev_wrap_lo", wrap, 0);
    cycles(20);
    measure(r_low, g_low, b_low);
    check_eq("rev_r", r_low, 8);
    check_eq("rev_g", g_low, 0);
    check_eq("rev_b_ramp7", b_low, 0);
    pulse();
    cycles(20);
    measure(r_low, g_low, b_low);
    check_eq("rev_b_ramp6", b_low, 1);
    dir = 1'b0;

    // HOLD at seg 2 ramp 3, then resume
    do_reset();
    repeat (19) pulse();
    cycles(20);
    check_eq("hold_pre_seg", segment, 2);
    measure(r_low, g_low, b_low);
    check_eq("hold_pre_r", r_low, 0);
    check_eq("hold_pre_g", g_low, 8);
    check_eq("hold_pre_b", b_low, 3);
    mode = 2'd1;
    cycles(100);
    check_eq("hold_seg", segment, 2);
    measure(r_low, g_low, b_low);
    check_eq("hold_b", b_low, 3);
    mode = 2'd0;
    cycles(4);
    mode = 2'd1;
    cycles(20);
    check_eq("resume_seg", segment, 2);
    measure(r_low, g_low, b_low);
    check_eq("resume_b", b_low, 4);

    // brightness change mid-period takes effect at the boundary
    mode = 2'd2;
    do_reset();
    repeat (4) pulse();
    cycles(20);
    found = 1'b0;
    prev_g = RGB_G;
    for (int i = 0; i < 32 && !found; i++) begin
      cycles(1);
      if (prev_g && !RGB_G) found = 1'b1;
      prev_g = RGB_G;
    end
    check_eq("period_start_found", found, 1);
    cycles(2);
    brightness = 8'd0;
    cycles(1);
    check_eq("tear_g_c3", RGB_G, 0);
    check_eq("tear_r_c3", RGB_R, 0);
    cycles(4);
    check_eq("tear_r_c7", RGB_R, 0);
    cycles(1);
    check_eq("new_r_c0", RGB_R, 1);
    check_eq("new_g_c0", RGB_G, 1);

    // OFF and en=0 darken within one clock; re-enable resumes duty
    brightness = 8'd255;
    cycles(20);
    check_eq("pre_off_r", RGB_R, 0);
    mode = 2'd3;
    cycles(1);
    check_eq("off_r", RGB_R, 1);
    check_eq("off_g", RGB_G, 1);
    check_eq("off_b", RGB_B, 1);
    cycles(10);
    check_eq("off_seg", segment, 0);
    check_eq("off_wrap", wrap, 0);
    mode = 2'd2;
    cycles(20);
    en = 1'b0;
    cycles(1);
    check_eq("en0_r", RGB_R, 1);
    en = 1'b1;
    cycles(20);
    measure(r_low, g_low, b_low);
    check_eq("reen_r", r_low, 8);
    check_eq("reen_g", g_low, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
